// File: rtl/gpio_if.sv
// Peripheral register-window bus: 16 registers of 16 bits, write strobe plus
// combinational read data.
interface gpio_if;
    logic        write;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output write, output addr, output wdata, input rdata);
    modport slave  (input write, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio.sv
// GPIO port: per-pin 2-flop synchroniser, optional prescaled glitch filter,
// level/edge interrupt status and a registered interrupt output.
module gpio #(
    parameter int unsigned NPINS = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    gpio_if.slave            io_bus,
    input  logic [NPINS-1:0] gpio_in_i,
    output logic [NPINS-1:0] gpio_out_o,
    output logic [NPINS-1:0] gpio_oe_o,
    output logic             gpio_intr_o
);

    localparam logic [3:0] AddrOut    = 4'd0;
    localparam logic [3:0] AddrOe     = 4'd1;
    localparam logic [3:0] AddrIn     = 4'd2;
    localparam logic [3:0] AddrOutSet = 4'd3;
    localparam logic [3:0] AddrOutClr = 4'd4;
    localparam logic [3:0] AddrIen    = 4'd5;
    localparam logic [3:0] AddrItype  = 4'd6;
    localparam logic [3:0] AddrIpol   = 4'd7;
    localparam logic [3:0] AddrIboth  = 4'd8;
    localparam logic [3:0] AddrStatus = 4'd9;
    localparam logic [3:0] AddrPend   = 4'd10;
    localparam logic [3:0] AddrFen    = 4'd11;
    localparam logic [3:0] AddrFpre   = 4'd12;

    logic [NPINS-1:0]      out_q, out_d, oe_q, oe_d, ien_q, ien_d;
    logic [NPINS-1:0]      itype_q, itype_d, ipol_q, ipol_d, iboth_q, iboth_d;
    logic [NPINS-1:0]      fen_q, fen_d, status_q, status_d;
    logic [7:0]            fpre_q, fpre_d, pre_q, pre_d;
    logic [NPINS-1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q, prev_d;
    logic [NPINS-1:0][1:0] cnt_q, cnt_d;
    logic [1:0]            guard_q, guard_d;
    logic                  intr_q, intr_d;

    logic [NPINS-1:0] wdata_p, w1c, to_edge, rise, fall, evt;
    logic             wr_status, wr_itype, wr_fpre, tick, guard_done;
    logic             unused_wdata;

    assign wdata_p      = io_bus.wdata[NPINS-1:0];
    assign unused_wdata = ^io_bus.wdata;
    assign wr_status    = io_bus.write && (io_bus.addr == AddrStatus);
    assign wr_itype     = io_bus.write && (io_bus.addr == AddrItype);
    assign wr_fpre      = io_bus.write && (io_bus.addr == AddrFpre);

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        ien_d   = ien_q;
        itype_d = itype_q;
        ipol_d  = ipol_q;
        iboth_d = iboth_q;
        fen_d   = fen_q;
        fpre_d  = fpre_q;
        if (io_bus.write) begin
            case (io_bus.addr)
                AddrOut:    out_d   = wdata_p;
                AddrOe:     oe_d    = wdata_p;
                AddrOutSet: out_d   = out_q | wdata_p;
                AddrOutClr: out_d   = out_q & ~wdata_p;
                AddrIen:    ien_d   = wdata_p;
                AddrItype:  itype_d = wdata_p;
                AddrIpol:   ipol_d  = wdata_p;
                AddrIboth:  iboth_d = wdata_p;
                AddrFen:    fen_d   = wdata_p;
                AddrFpre:   fpre_d  = io_bus.wdata[7:0];
                default: ;
            endcase
        end
    end

    // Prescaler restarts whenever FPRE is rewritten.
    assign tick  = (pre_q == fpre_q);
    assign pre_d = (wr_fpre || tick) ? 8'd0 : pre_q + 8'd1;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NPINS; i++) begin
            if (!fen_q[i]) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = 2'd0;
            end else if (tick) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_d[i] = 2'd0;
                end else if (cnt_q[i] == 2'd2) begin
                    filt_d[i] = sync2_q[i];
                    cnt_d[i]  = 2'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end
            end
        end
    end

    // While the startup guard runs, prev shadows the next filt so the first
    // valid comparison never sees a pin that was already high at reset.
    assign guard_done = (guard_q == 2'd3);
    assign guard_d    = guard_done ? guard_q : guard_q + 2'd1;
    assign prev_d     = guard_done ? filt_q : filt_d;

    assign rise = filt_q & ~prev_q;
    assign fall = ~filt_q & prev_q;
    assign evt  = guard_done ? ((iboth_q & (rise | fall)) |
                                (~iboth_q & ipol_q & rise) |
                                (~iboth_q & ~ipol_q & fall)) : '0;

    assign w1c     = wr_status ? wdata_p : '0;
    assign to_edge = wr_itype ? (wdata_p & ~itype_q) : '0;

    // Edge bits: sticky, set beats clear. Level bits: track filt each cycle.
    assign status_d = (itype_q & ((status_q & ~w1c) | evt)) |
                      (~itype_q & ~to_edge & ~(filt_q ^ ipol_q));
    assign intr_d   = |(status_q & ien_q);

    always_comb begin
        io_bus.rdata = '0;
        case (io_bus.addr)
            AddrOut, AddrOutSet, AddrOutClr: io_bus.rdata[NPINS-1:0] = out_q;
            AddrOe:     io_bus.rdata[NPINS-1:0] = oe_q;
            AddrIn:     io_bus.rdata[NPINS-1:0] = filt_q;
            AddrIen:    io_bus.rdata[NPINS-1:0] = ien_q;
            AddrItype:  io_bus.rdata[NPINS-1:0] = itype_q;
            AddrIpol:   io_bus.rdata[NPINS-1:0] = ipol_q;
            AddrIboth:  io_bus.rdata[NPINS-1:0] = iboth_q;
            AddrStatus: io_bus.rdata[NPINS-1:0] = status_q;
            AddrPend:   io_bus.rdata[NPINS-1:0] = status_q & ien_q;
            AddrFen:    io_bus.rdata[NPINS-1:0] = fen_q;
            AddrFpre:   io_bus.rdata[7:0]       = fpre_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q    <= '0;
            oe_q     <= '0;
            ien_q    <= '0;
            itype_q  <= '0;
            ipol_q   <= '0;
            iboth_q  <= '0;
            fen_q    <= '0;
            fpre_q   <= '0;
            pre_q    <= '0;
            status_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            guard_q  <= '0;
            intr_q   <= 1'b0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            ien_q    <= ien_d;
            itype_q  <= itype_d;
            ipol_q   <= ipol_d;
            iboth_q  <= iboth_d;
            fen_q    <= fen_d;
            fpre_q   <= fpre_d;
            pre_q    <= pre_d;
            status_q <= status_d;
            sync1_q  <= gpio_in_i;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            guard_q  <= guard_d;
            intr_q   <= intr_d;
        end
    end

    assign gpio_out_o  = out_q;
    assign gpio_oe_o   = oe_q;
    assign gpio_intr_o = intr_q;

endmodule

// File: doc/gpio.md
# gpio

General-purpose I/O port with per-pin input synchronisation, optional glitch filtering, and configurable level or edge interrupt detection. It sits directly upstream of the interrupt controller. Its `gpio_intr` output drives that controller's gpio status bit (bit 4), which the controller ANDs with its own enable. Software accesses the port through the same 16-register, 16-bit I/O window used by the other peripherals.

## Interface
- `NPINS`, default 8: number of pins, legal range 1..16. Register bits above `NPINS-1` read 0 and ignore writes.
- `clk`  in  1  single clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low; all flops clear while low.
- `gpio_in`  in  NPINS  pad inputs, asynchronous to `clk`.
- `gpio_out`  out  NPINS  output data, driven directly from the OUT register.
- `gpio_oe`  out  NPINS  output enables, driven directly from the OE register.
- `gpio_intr`  out  1  level interrupt, |(STATUS & IEN), driven from flops only.
- `io_write`  in  1  register write strobe, one cycle per write.
- `io_addr`  in  4  register select.
- `io_wdata`  in  16  write data.
- `io_rdata`  out  16  combinational read data for `io_addr`; reads have no side effects.

## Operation
- Register map (RW unless marked):
  - 0 OUT.
  - 1 OE.
  - 2 IN (RO): filtered input value.
  - 3 OUTSET: write-1-sets OUT bits; reads return OUT.
  - 4 OUTCLR: write-1-clears OUT bits; reads return OUT.
  - 5 IEN: interrupt enable.
  - 6 ITYPE: 1 = edge, 0 = level.
  - 7 IPOL: level mode, 1 = active-high; edge mode, 1 = rising.
  - 8 IBOTH: edge mode only; 1 = both edges, overrides IPOL.
  - 9 STATUS: write-1-clears edge bits.
  - 10 PENDING (RO): STATUS & IEN.
  - 11 FEN: per-pin filter enable.
  - 12 FPRE: prescale value, bits [7:0].
  - 13–15: read 0, writes ignored.
- Synchroniser: each pin passes through 2 flops, giving `sync`.
- Glitch filter:
  - An 8-bit prescaler counts 0..FPRE, then wraps to 0; a tick is issued on the wrap. FPRE=0 gives a tick every cycle.
  - Each filtered pin has a 2-bit stability counter. On each tick:
    - if `sync` equals `filt`, the counter is cleared;
    - otherwise the counter increments, and when it reaches 3, `filt` takes `sync` and the counter clears.
  - Unfiltered pins: `filt` follows `sync` every cycle.
  - Clearing a FEN bit clears that pin's counter.
- Edge detect: `prev` registers `filt` every cycle.
  - Rising edge = `filt & ~prev`; falling edge = `~filt & prev`.
- STATUS, edge pins: a bit sets on a qualifying edge and is sticky until software clears it. It sets regardless of IEN.
- STATUS, level pins: the bit equals `filt` XNOR IPOL each cycle. STATUS writes are ignored.
- Changing ITYPE from level to edge clears that STATUS bit.
- Startup guard:
  - A 2-bit counter increments from reset release and saturates at 3.
  - Edge detection is suppressed until it reaches 3, so pins that are high at reset do not produce a spurious rising edge.

## Timing
- Reset values:
  - `gpio_out`, `gpio_oe`, `gpio_intr` = 0.
  - All registers, sync flops, `filt`, `prev`, prescaler, stability counters and startup counter = 0.
- Register writes take effect on the clock edge where `io_write` is high. `gpio_out`/`gpio_oe` change in the same cycle the write is sampled (visible after that edge).
- Input to IN latency, unfiltered: 3 cycles (2 sync flops + `filt`).
- Input to `gpio_intr`, edge mode, unfiltered: 5 cycles (2 sync + `filt` + STATUS + `gpio_intr` flop).
- Filtered latency: 3 consecutive ticks of stable input, plus the pipeline above.
- Simultaneous edge event and W1C on the same bit: set wins.
- A W1C of an edge bit deasserts `gpio_intr` one cycle after the write edge, provided no other pending bit remains.
- Pulses shorter than one clock may be missed; this is not an error.
- FPRE written mid-count: the prescaler restarts from 0.
- Reset asserted mid-filter: all state clears immediately. Edge detection stays suppressed until 3 cycles after reset release.

## Test plan
- **Output path:** write OUT=0x00A5, then OUTSET=0x0002, then OUTCLR=0x0001 → `gpio_out` = 0xA5, 0xA7, 0xA6 after the respective writes. Write OE=0xFF → `gpio_oe` = 0xFF.
- **Rising-edge interrupt:** ITYPE=0x01, IPOL=0x01, IEN=0x01, raise `gpio_in[0]` → STATUS=0x0001 and `gpio_intr`=1 exactly 5 cycles later. Write STATUS=0x0001 → `gpio_intr`=0 one cycle later, STATUS=0.
- **Level and both-edge modes:**
  - Pin 3 in level mode, active-low: hold `gpio_in[3]`=0 → STATUS[3]=1; set the pin to 1 → STATUS[3]=0 after 4 cycles.
  - Pin 2 with IBOTH=1: pulse the pin 0→1→0, clearing STATUS between the edges → STATUS[2] sets on both edges.
- **Glitch filter:** FEN=0x01, FPRE=3, input glitch high for 8 cycles → IN[0] stays 0 and no STATUS set. Input held high for 16 cycles → IN[0]=1, STATUS[0]=1.
- **Set/clear race:** a W1C of STATUS[0] lands on the same cycle as a new rising edge on pin 0 → STATUS[0] remains 1.
- **Reset behaviour:** all pins high, async reset pulse mid-cycle → outputs 0 immediately. After release with IEN=0xFF, ITYPE=0xFF, IPOL=0xFF → STATUS stays 0 (no spurious edge). Read of address 14 → 0x0000.
